// File: rtl/keypad_encoder_4x4.sv
// 4x4 hex keypad scanner/encoder with debounce, one-cycle valid strobe and held flag.
// Optional macro KEYPAD_DIGIT_SHIFT_EN: digits becomes a two-digit shift register of
// accepted codes; without it digits is {4'h0, code}.
module keypad_encoder_4x4 #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] code,
   output logic       valid,
   output logic       pressed,
   output logic [7:0] digits
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [3:0]      row_s1, row_s2;
   logic [DW-1:0]   dwell;
   logic [1:0]      col_idx;
   logic [1:0]      row_idx;
   logic [CW-1:0]   stable_cnt, stable_nxt;
   logic [CW-1:0]   release_cnt, release_nxt;
   logic            sample_en;
   logic            row_low;
   logic            advance, latch, accept, release_done;

   // Lowest-index closed row in the sampled row vector
   function automatic logic [1:0] first_low(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   // Physical keypad legend for row r / column c
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
      endcase
   endfunction

   assign sample_en = (dwell == DWELL_LAST);
   assign row_low   = ~row_s2[row_idx];

   // Two-flop synchronizer for the asynchronous row inputs; idle rows read high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   // Column dwell counter; the last count of each dwell is the sample cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dwell <= '0;
      else          dwell <= sample_en ? '0 : dwell + DW'(1);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= SCAN;
      else          state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         SCAN:     if (sample_en && row_s2 != 4'hF) state_nxt = DEBOUNCE;
         DEBOUNCE: if (sample_en) begin
                      if (!row_low)                    state_nxt = SCAN;
                      else if (stable_cnt == CNT_LAST) state_nxt = HELD;
                   end
         HELD:     if (sample_en && !row_low && release_cnt == CNT_LAST) state_nxt = SCAN;
         default:  state_nxt = SCAN;
      endcase
   end

   // FSM output strobes and counter next values
   always_comb begin
      advance      = 1'b0;
      latch        = 1'b0;
      accept       = 1'b0;
      release_done = 1'b0;
      stable_nxt   = stable_cnt;
      release_nxt  = release_cnt;
      case (state)
         SCAN: begin
            release_nxt = '0;
            if (sample_en) begin
               if (row_s2 == 4'hF) begin
                  advance = 1'b1;
               end else begin
                  latch      = 1'b1;
                  stable_nxt = CW'(1);
               end
            end
         end
         DEBOUNCE: begin
            if (sample_en) begin
               if (row_low) begin
                  stable_nxt = stable_cnt + CW'(1);
                  accept     = (stable_cnt == CNT_LAST);
               end else begin
                  advance    = 1'b1;
                  stable_nxt = '0;
               end
            end
         end
         HELD: begin
            if (sample_en) begin
               if (row_low) begin
                  release_nxt = '0;
               end else begin
                  release_nxt = release_cnt + CW'(1);
                  if (release_cnt == CNT_LAST) begin
                     release_done = 1'b1;
                     advance      = 1'b1;
                     stable_nxt   = '0;
                  end
               end
            end
         end
         default: begin
            stable_nxt  = '0;
            release_nxt = '0;
         end
      endcase
   end

   // Column drive, latched key position, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_n       <= 4'b1110;
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         stable_cnt  <= '0;
         release_cnt <= '0;
         code        <= 4'h0;
         valid       <= 1'b0;
         pressed     <= 1'b0;
      end else begin
         stable_cnt  <= stable_nxt;
         release_cnt <= release_nxt;
         valid       <= accept;
         if (advance) begin
            col_n   <= {col_n[2:0], col_n[3]};
            col_idx <= col_idx + 2'd1;
         end
         if (latch) row_idx <= first_low(row_s2);
         if (accept) begin
            code    <= key_code(row_idx, col_idx);
            pressed <= 1'b1;
         end else if (release_done) begin
            pressed <= 1'b0;
         end
      end
   end

`ifdef KEYPAD_DIGIT_SHIFT_EN
   logic [7:0] digits_q;

   // Two-digit history: older key moves to the upper digit on each accepted key
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    digits_q <= 8'h00;
      else if (accept) digits_q <= {digits_q[3:0], key_code(row_idx, col_idx)};
   end

   assign digits = digits_q;
`else
   assign digits = {4'h0, code};
`endif

endmodule

// File: tb/tb_keypad_encoder_4x4.sv
// Directed bench for keypad_encoder_4x4 with a behavioural keypad matrix and a code scoreboard.
module tb_keypad_encoder_4x4;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEB      = 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] code;
   logic       valid;
   logic       pressed;
   logic [7:0] digits;

   logic [15:0] keys;       // bit r*4+c = key at row r, column c is closed
   int          n_cmp   = 0;
   int          n_bad   = 0;
   int          n_valid = 0;
   int          v_exp   = 0;
   int          lat;
   logic [3:0]  exp_q[$];

   keypad_encoder_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .row_n   (row_n),
      .col_n   (col_n),
      .code    (code),
      .valid   (valid),
      .pressed (pressed),
      .digits  (digits)
   );

   always #5 clk = ~clk;

   // Passive keypad: a row is pulled low when a closed key sits in the driven column
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_col(input logic [3:0] target, input string tag);
      for (int i = 0; i < 40 && col_n !== target; i++) tick(1);
      chk(tag, 8'(col_n), 8'(target));
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (valid !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      chk(tag, 8'(valid), 8'h1);
   endtask

   task automatic wait_release(input string tag);
      for (int i = 0; i < 200 && pressed !== 1'b0; i++) tick(1);
      chk(tag, 8'(pressed), 8'h0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_col"},     8'(col_n),   8'h0E);
      chk({tag, "_code"},    8'(code),    8'h00);
      chk({tag, "_valid"},   8'(valid),   8'h00);
      chk({tag, "_pressed"}, 8'(pressed), 8'h00);
      chk({tag, "_digits"},  digits,      8'h00);
   endtask

   // Scoreboard: every valid strobe must match the oldest expected key
   always @(negedge clk) begin
      if (reset_n === 1'b1 && valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) chk("spurious_valid", 8'(valid), 8'h0);
         else                   chk("sb_code", 8'(code), 8'(exp_q.pop_front()));
      end
   end

   initial begin
      keys    = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset_n = 1'b1;

      // Idle scan: column rotates every SCAN_DIV cycles
      tick(SCAN_DIV - 1); chk("col0_dwell", 8'(col_n), 8'h0E);
      tick(1);            chk("col1",       8'(col_n), 8'h0D);
      tick(SCAN_DIV);     chk("col2",       8'(col_n), 8'h0B);
      tick(SCAN_DIV);     chk("col3",       8'(col_n), 8'h07);
      tick(SCAN_DIV);     chk("col_wrap",   8'(col_n), 8'h0E);

      // Key 5 (row1, col1): latency, freeze, hold, release
      keys = 16'(1) << 5;
      wait_col(4'b1101, "k5_col1");
      exp_q.push_back(4'h5);
      v_exp++;
      wait_valid("k5_valid", lat);
      chk("k5_latency", 8'(lat), 8'(SCAN_DIV * DEB));
      chk("k5_code",    8'(code), 8'h05);
      chk("k5_pressed", 8'(pressed), 8'h01);
      tick(1);
      chk("k5_valid_pulse", 8'(valid), 8'h00);
      tick(20);
      chk("k5_col_frozen", 8'(col_n), 8'h0D);
      chk("k5_still_held", 8'(pressed), 8'h01);
      keys = '0;
      wait_release("k5_release");
      chk("k5_resume_col2", 8'(col_n), 8'h0B);
      chk("k5_code_kept", 8'(code), 8'h05);

      // Bounce: two low samples then high -> no key accepted
      keys = 16'(1) << 5;
      wait_col(4'b1101, "bounce_col1");
      tick(2 * SCAN_DIV + 1);
      keys = '0;
      tick(SCAN_DIV);
      chk("bounce_col_adv", 8'(col_n), 8'h0B);
      chk("bounce_pressed", 8'(pressed), 8'h00);
      chk("bounce_code",    8'(code), 8'h05);
      chk("bounce_no_valid", 8'(n_valid), 8'(v_exp));

      // Rows 2 and 3 in column 3: row 2 (C) wins; long hold gives one valid
      keys = (16'(1) << 11) | (16'(1) << 15);
      exp_q.push_back(4'hC);
      v_exp++;
      wait_valid("kc_valid", lat);
      chk("kc_code", 8'(code), 8'h0C);
      tick(20 * SCAN_DIV);
      chk("kc_one_valid", 8'(n_valid), 8'(v_exp));
      chk("kc_held", 8'(pressed), 8'h01);
      keys = '0;
      wait_release("kc_release");
      chk("kc_resume_col0", 8'(col_n), 8'h0E);

      // Key 3 then key A: digit display path
      keys = 16'(1) << 2;
      exp_q.push_back(4'h3);
      v_exp++;
      wait_valid("k3_valid", lat);
      chk("k3_code", 8'(code), 8'h03);
`ifdef KEYPAD_DIGIT_SHIFT_EN
      chk("k3_digits", digits, 8'hC3);
`else
      chk("k3_digits", digits, 8'h03);
`endif
      keys = '0;
      wait_release("k3_release");
      chk("k3_resume_col3", 8'(col_n), 8'h07);
      keys = 16'(1) << 3;
      exp_q.push_back(4'hA);
      v_exp++;
      wait_valid("ka_valid", lat);
      chk("ka_code", 8'(code), 8'h0A);
`ifdef KEYPAD_DIGIT_SHIFT_EN
      chk("ka_digits", digits, 8'h3A);
`else
      chk("ka_digits", digits, 8'h0A);
`endif
      keys = '0;
      wait_release("ka_release");
      chk("ka_resume_col0", 8'(col_n), 8'h0E);

      // Reset in the middle of debounce after two good samples
      keys = 16'(1) << 5;
      wait_col(4'b1101, "rst_col1");
      tick(2 * SCAN_DIV + 1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      keys = '0;
      tick(2);
      reset_n = 1'b1;
      tick(SCAN_DIV - 1); chk("midrst_col0", 8'(col_n), 8'h0E);
      tick(1);            chk("midrst_col1", 8'(col_n), 8'h0D);
      tick(20);
      chk("final_valid_count", 8'(n_valid), 8'(v_exp));
      chk("sb_drained", 8'(exp_q.size()), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_encoder_4x4.md
Name: keypad_encoder_4x4

Overview:
- Scans a 4x4 matrix hex keypad and encodes the pressed key into a 4-bit hex code, with debounce and a one-cycle valid strobe.
- It is the input-side counterpart of the 7-segment decoder path: its code output feeds the decoder's 4-bit digit input directly.
- Sits between the board keypad header pins and the display logic.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_CNT, 8, consecutive identical samples required to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- row_n  input  4  keypad rows, externally pulled up; low = key closed in the driven column
- col_n  output  4  keypad column drive, one-hot active-low
- code  output  4  hex code of the last accepted key
- valid  output  1  one-cycle pulse when a new key is accepted
- pressed  output  1  high while the accepted key is held
- digits  output  8  two-digit value for the HEX1/HEX0 displays (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): col_n=4'b1110, code=0, valid=0, pressed=0, digits=0, state=SCAN, all counters 0.
- row_n passes through a 2-FF synchronizer. "Sample" means the synchronized rows in the cycle where dwell counter == SCAN_DIV-1.
- The dwell counter wraps to 0 after SCAN_DIV-1.
- Column advance: rotate col_n left (1110 -> 1101 -> 1011 -> 0111 -> 1110) on the cycle after a sample, but only in the states listed below.
- Key map, row r / column c = 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN:
  - Sample == 4'hF: advance column.
  - Otherwise: latch the current column and the lowest-index low row, set stable_cnt=1, go to DEBOUNCE. The column does not advance.
- DEBOUNCE (column frozen):
  - Latched row low at a sample: stable_cnt++.
  - When stable_cnt reaches DEBOUNCE_CNT: load code from the map, pulse valid for exactly one cycle, set pressed=1, go to HELD.
  - Latched row high at a sample: go to SCAN with no valid, and advance the column.
- HELD (column frozen):
  - Latched row high at a sample: release_cnt++. Latched row low: release_cnt=0.
  - When release_cnt reaches DEBOUNCE_CNT: pressed=0, go to SCAN, advance the column.
  - Other keys pressed during HELD are ignored.
- Latency: valid rises the cycle after the (DEBOUNCE_CNT)th consecutive low sample, counting the detection sample as the first.
- Multiple keys in one column: lowest row wins. Keys in different columns: first column scanned wins.
- code holds its value until the next accepted key. It is not cleared on release.
- Reset mid-DEBOUNCE or mid-HELD: return immediately to reset values. No valid is emitted.
- Counters are $clog2-sized and never overflow: they saturate at the compare value, then the state changes.

Optional Feature:
- Macro: KEYPAD_DIGIT_SHIFT_EN.
- Defined: on each valid pulse, digits <= {digits[3:0], new code}. Reset clears it to 8'h00.
- Undefined: digits = {4'h0, code} (combinational), and no shift register is built.

Test Plan:
- Reset with row_n=4'hF, SCAN_DIV=4, DEBOUNCE_CNT=3 -> col_n=1110, code=0, valid=0, pressed=0; col_n rotates every 4 cycles.
- Hold row1 low whenever col1 is driven (key 5) -> column freezes at 1101; valid pulses once, 3 samples after detection; code=4'h5, pressed=1; release for 3 samples -> pressed=0, scanning resumes at col2.
- Bounce: row1 low for 2 samples, then high -> no valid, code unchanged, return to SCAN.
- Rows 2 and 3 both low in col3 -> code=4'hC (row2 wins). Hold 20 samples -> exactly one valid.
- With KEYPAD_DIGIT_SHIFT_EN, press 3 then A (full release between) -> digits=8'h3A. Without the macro -> digits=8'h0A.
- Assert reset_n=0 during DEBOUNCE after 2 good samples -> all outputs return to reset values, no valid. After reset, scanning restarts at col0.
